// File: rtl/multi_voice_sampler.sv
// N-voice drum sample player: each voice walks its own external ROM, and the
// active voices are volume-scaled, summed and saturated once per sample tick.
module multi_voice_sampler #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         sample_tick,
    input  logic [NUM_VOICES-1:0]        trig,
    input  logic [NUM_VOICES-1:0]        stop,
    input  logic [NUM_VOICES-1:0]        loop_en,
    input  logic [NUM_VOICES*ADDR_W-1:0] len,
    input  logic [NUM_VOICES*4-1:0]      vol,
    output logic [NUM_VOICES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_VOICES*DATA_W-1:0] rom_data,
    output logic [NUM_VOICES-1:0]        active,
    output logic [OUT_W-1:0]             out_sample,
    output logic                         out_valid
);

    localparam int SUM_W  = DATA_W + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = DATA_W + 5;
    localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'((2 ** OUT_W) - 1);

    logic [ADDR_W-1:0]     addr_q [NUM_VOICES];
    logic [ADDR_W-1:0]     addr_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [OUT_W-1:0]      out_sample_q, out_sample_d;
    logic                  out_valid_q, out_valid_d;
    logic [SUM_W-1:0]      mix_sum;
    logic [PROD_W-1:0]     prod;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q     <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            active_q     <= active_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    // Per-voice IDLE/PLAY transitions; trig outranks stop, which outranks advance.
    always_comb begin
        active_d = active_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            addr_d[i] = addr_q[i];
            if (trig[i]) begin
                active_d[i] = 1'b1;
                addr_d[i]   = '0;
            end else if (stop[i]) begin
                active_d[i] = 1'b0;
                addr_d[i]   = '0;
            end else if (sample_tick && active_q[i]) begin
                if (addr_q[i] == len[i*ADDR_W +: ADDR_W]) begin
                    active_d[i] = loop_en[i];
                    addr_d[i]   = '0;
                end else begin
                    addr_d[i] = addr_q[i] + ADDR_W'(1);
                end
            end
        end
    end

    // Mix uses the pre-edge active flags, so a one-shot's last sample is still heard.
    always_comb begin
        mix_sum = '0;
        prod    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            prod = PROD_W'(rom_data[i*DATA_W +: DATA_W])
                 * PROD_W'({1'b0, vol[i*4 +: 4]} + 5'd1);
            if (active_q[i]) begin
                mix_sum = mix_sum + SUM_W'(prod >> 4);
            end
        end
        out_valid_d  = sample_tick;
        out_sample_d = out_sample_q;
        if (sample_tick) begin
            out_sample_d = (mix_sum > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : mix_sum[OUT_W-1:0];
        end
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            rom_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
        end
    end

    assign active     = active_q;
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_multi_voice_sampler.sv
// Self-checking bench for multi_voice_sampler: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_multi_voice_sampler;

    localparam int NV = 4;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int OW = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              sample_tick = 1'b0;
    logic [NV-1:0]     trig = '0;
    logic [NV-1:0]     stop = '0;
    logic [NV-1:0]     loop_en = '0;
    logic [NV*AW-1:0]  len = '0;
    logic [NV*4-1:0]   vol = '0;
    logic [NV*AW-1:0]  rom_addr;
    logic [NV*DW-1:0]  rom_data = '0;
    logic [NV-1:0]     active;
    logic [OW-1:0]     out_sample;
    logic              out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NV-1:0] rom_const_en = '0;
    logic [DW-1:0] rom_const [NV];

    multi_voice_sampler #(
        .NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)
    ) dut (
        .clk(clk), .resetn(resetn), .sample_tick(sample_tick),
        .trig(trig), .stop(stop), .loop_en(loop_en), .len(len), .vol(vol),
        .rom_addr(rom_addr), .rom_data(rom_data), .active(active),
        .out_sample(out_sample), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // ROM content: either a per-voice constant or address+10.
    function automatic logic [DW-1:0] rom_val(int i, logic [AW-1:0] a);
        return rom_const_en[i] ? rom_const[i] : DW'(a + 10);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NV; i++) begin
            rom_data[i*DW +: DW] <= rom_val(i, rom_addr[i*AW +: AW]);
        end
    end

    // Behavioural model: voice position/playing flag as plain integers.
    bit m_active [NV];
    int m_addr   [NV];
    int m_data   [NV];
    int m_out   = 0;
    bit m_valid = 0;
    int m_next  [NV];
    int m_sum;

    always @(posedge clk) begin
        for (int i = 0; i < NV; i++) m_next[i] = int'(rom_val(i, AW'(m_addr[i])));
        if (!resetn) begin
            m_valid = 0;
            m_out   = 0;
            for (int i = 0; i < NV; i++) begin
                m_active[i] = 0;
                m_addr[i]   = 0;
            end
        end else begin
            m_valid = sample_tick;
            if (sample_tick) begin
                m_sum = 0;
                for (int i = 0; i < NV; i++)
                    if (m_active[i]) m_sum += m_data[i] * (int'(vol[i*4 +: 4]) + 1) / 16;
                m_out = (m_sum > 255) ? 255 : m_sum;
            end
            for (int i = 0; i < NV; i++) begin
                if (trig[i]) begin
                    m_active[i] = 1;
                    m_addr[i]   = 0;
                end else if (stop[i]) begin
                    m_active[i] = 0;
                    m_addr[i]   = 0;
                end else if (sample_tick && m_active[i]) begin
                    if (m_addr[i] == int'(len[i*AW +: AW])) begin
                        m_addr[i]   = 0;
                        m_active[i] = loop_en[i];
                    end else begin
                        m_addr[i] = (m_addr[i] + 1) % (1 << AW);
                    end
                end
            end
        end
        for (int i = 0; i < NV; i++) m_data[i] = m_next[i];
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_trig(logic [NV-1:0] m);
        trig = m;
        @(negedge clk);
        trig = '0;
    endtask

    task automatic strobe_stop(logic [NV-1:0] m);
        stop = m;
        @(negedge clk);
        stop = '0;
    endtask

    task automatic strobe_tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        trig   = '1;
        for (int c = 0; c < 3; c++) begin
            sample_tick = (c != 1);
            @(negedge clk);
            n_checks += 4;
            if (active !== '0) begin
                n_fail++; $display("[TB] FAIL reset_active: got %h expected 0", active);
            end
            if (rom_addr !== '0) begin
                n_fail++; $display("[TB] FAIL reset_rom_addr: got %h expected 0", rom_addr);
            end
            if (out_sample !== '0) begin
                n_fail++; $display("[TB] FAIL reset_out_sample: got %0d expected 0", out_sample);
            end
            if (out_valid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
            end
        end
        trig        = '0;
        sample_tick = 1'b0;
        resetn      = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_one_shot();
        int exp_out [5] = '{10, 11, 12, 13, 0};
        rom_const_en    = '0;
        len[0 +: AW]    = 13'd3;
        vol[0 +: 4]     = 4'd15;
        loop_en[0]      = 1'b0;
        strobe_trig(4'b0001);
        wait_cyc(1);
        for (int k = 0; k < 5; k++) begin
            strobe_tick();
            n_checks += 3;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("[TB] FAIL oneshot_valid[%0d]: got %b expected 1", k, out_valid);
            end
            if (out_sample !== OW'(exp_out[k])) begin
                n_fail++; $display("[TB] FAIL oneshot_sample[%0d]: got %0d expected %0d", k, out_sample, exp_out[k]);
            end
            if (active[0] !== (k < 3)) begin
                n_fail++; $display("[TB] FAIL oneshot_active[%0d]: got %b expected %b", k, active[0], k < 3);
            end
            wait_cyc(1);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL oneshot_valid_pulse[%0d]: got %b expected 0", k, out_valid);
            end
            wait_cyc(2);
        end
        n_checks++;
        if (rom_addr[0 +: AW] !== '0) begin
            n_fail++; $display("[TB] FAIL oneshot_addr_end: got %0d expected 0", rom_addr[0 +: AW]);
        end
    endtask

    task automatic test_loop();
        int exp_addr [7] = '{1, 2, 0, 1, 2, 0, 1};
        len[AW +: AW] = 13'd2;
        loop_en[1]    = 1'b1;
        vol[4 +: 4]   = 4'd15;
        strobe_trig(4'b0010);
        wait_cyc(1);
        for (int k = 0; k < 7; k++) begin
            strobe_tick();
            n_checks += 2;
            if (rom_addr[AW +: AW] !== AW'(exp_addr[k])) begin
                n_fail++; $display("[TB] FAIL loop_addr[%0d]: got %0d expected %0d", k, rom_addr[AW +: AW], exp_addr[k]);
            end
            if (active[1] !== 1'b1) begin
                n_fail++; $display("[TB] FAIL loop_active[%0d]: got %b expected 1", k, active[1]);
            end
            wait_cyc(3);
        end
        strobe_stop(4'b0010);
        n_checks += 2;
        if (active[1] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL loop_stop_active: got %b expected 0", active[1]);
        end
        if (rom_addr[AW +: AW] !== '0) begin
            n_fail++; $display("[TB] FAIL loop_stop_addr: got %0d expected 0", rom_addr[AW +: AW]);
        end
        loop_en[1] = 1'b0;
    endtask

    task automatic test_volume();
        logic [3:0] vols [3] = '{4'd7, 4'd0, 4'd15};
        int exp_out [3] = '{100, 12, 200};
        rom_const_en[2] = 1'b1;
        rom_const[2]    = 8'd200;
        len[2*AW +: AW] = 13'd1000;
        loop_en[2]      = 1'b0;
        vol[8 +: 4]     = vols[0];
        wait_cyc(1);
        strobe_trig(4'b0100);
        wait_cyc(1);
        for (int k = 0; k < 3; k++) begin
            vol[8 +: 4] = vols[k];
            strobe_tick();
            n_checks++;
            if (out_sample !== OW'(exp_out[k])) begin
                n_fail++; $display("[TB] FAIL volume[%0d]: got %0d expected %0d", vols[k], out_sample, exp_out[k]);
            end
            wait_cyc(3);
        end
        strobe_stop(4'b0100);
    endtask

    task automatic test_saturation();
        rom_const_en = '1;
        for (int i = 0; i < NV; i++) begin
            rom_const[i]     = 8'd200;
            len[i*AW +: AW]  = 13'd1000;
            vol[i*4 +: 4]    = 4'd15;
        end
        loop_en = '0;
        wait_cyc(1);
        strobe_trig(4'b1111);
        wait_cyc(1);
        strobe_tick();
        n_checks++;
        if (out_sample !== 8'd255) begin
            n_fail++; $display("[TB] FAIL saturate_4x200: got %0d expected 255", out_sample);
        end
        wait_cyc(2);
        strobe_stop(4'b1100);
        rom_const[0] = 8'd100;
        rom_const[1] = 8'd100;
        wait_cyc(2);
        strobe_tick();
        n_checks++;
        if (out_sample !== 8'd200) begin
            n_fail++; $display("[TB] FAIL saturate_2x100: got %0d expected 200", out_sample);
        end
        wait_cyc(2);
        strobe_stop(4'b1111);
    endtask

    task automatic test_priority();
        rom_const_en     = '0;
        len[3*AW +: AW]  = 13'd1000;
        vol[12 +: 4]     = 4'd15;
        loop_en[3]       = 1'b0;
        strobe_trig(4'b1000);
        wait_cyc(1);
        repeat (5) begin
            strobe_tick();
            wait_cyc(3);
        end
        n_checks++;
        if (rom_addr[3*AW +: AW] !== 13'd5) begin
            n_fail++; $display("[TB] FAIL priority_pre_addr: got %0d expected 5", rom_addr[3*AW +: AW]);
        end
        trig        = 4'b1000;
        stop        = 4'b1000;
        sample_tick = 1'b1;
        @(negedge clk);
        trig        = '0;
        stop        = '0;
        sample_tick = 1'b0;
        n_checks += 3;
        if (active[3] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL priority_active: got %b expected 1", active[3]);
        end
        if (rom_addr[3*AW +: AW] !== '0) begin
            n_fail++; $display("[TB] FAIL priority_addr: got %0d expected 0", rom_addr[3*AW +: AW]);
        end
        if (out_sample !== 8'd15) begin
            n_fail++; $display("[TB] FAIL priority_mix: got %0d expected 15", out_sample);
        end
        wait_cyc(2);
        strobe_stop(4'b1000);
    endtask

    task automatic test_random();
        int since_tick = 10;
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 0) begin
                for (int i = 0; i < NV; i++) begin
                    len[i*AW +: AW] = AW'($urandom_range(0, 6));
                    rom_const[i]    = DW'($urandom);
                end
                loop_en      = NV'($urandom);
                rom_const_en = NV'($urandom);
            end
            @(negedge clk);
            n_checks += 2 + 2 * NV;
            for (int i = 0; i < NV; i++) begin
                if (active[i] !== m_active[i]) begin
                    n_fail++; $display("[TB] FAIL rand_active%0d @%0d: got %b expected %b", i, c, active[i], m_active[i]);
                end
                if (rom_addr[i*AW +: AW] !== AW'(m_addr[i])) begin
                    n_fail++; $display("[TB] FAIL rand_addr%0d @%0d: got %0d expected %0d", i, c, rom_addr[i*AW +: AW], m_addr[i]);
                end
            end
            if (out_sample !== OW'(m_out)) begin
                n_fail++; $display("[TB] FAIL rand_sample @%0d: got %0d expected %0d", c, out_sample, m_out);
            end
            if (out_valid !== m_valid) begin
                n_fail++; $display("[TB] FAIL rand_valid @%0d: got %b expected %b", c, out_valid, m_valid);
            end
            resetn = (c != 300);
            for (int i = 0; i < NV; i++) begin
                trig[i]      = ($urandom_range(0, 15) == 0);
                stop[i]      = ($urandom_range(0, 19) == 0);
                vol[i*4 +: 4] = 4'($urandom);
            end
            sample_tick = (since_tick >= 2) && ($urandom_range(0, 2) == 0);
            since_tick  = sample_tick ? 1 : since_tick + 1;
        end
        @(negedge clk);
        trig        = '0;
        stop        = '0;
        sample_tick = 1'b0;
        resetn      = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NV; i++) rom_const[i] = '0;
        test_reset();
        test_one_shot();
        test_loop();
        test_volume();
        test_saturation();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
